// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and widths for the AES job arbiter.
//   - aes_arb_state_e : arbiter FSM states (IDLE -> ARB -> ISSUE -> RELEASE)
//   - N_REQ           : number of requesters (2)
//   - IDX_W           : width of a requester index
//   - KEY_W/ADDR_W/LOC_W : per-job command field widths (128/8/8)
package aes_arb_pkg;

  localparam int N_REQ  = 2;
  localparam int IDX_W  = 1;
  localparam int KEY_W  = 128;
  localparam int ADDR_W = 8;
  localparam int LOC_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_RELEASE = 2'd3
  } aes_arb_state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: two-way round-robin pick with a last-grant pointer.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   req        : current request vector
//   advance    : load owner_idx into the last-grant pointer (job released)
//   owner_idx  : index of the requester that just finished
//   pick       : one-hot winner (zero when req is zero)
//   pick_idx   : index of the winner
module aes_rr_arbiter
  import aes_arb_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] owner_idx,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W-1:0] last_idx_q;

  // Reset to requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_idx_q <= 1'b1;
    end else if (advance) begin
      last_idx_q <= owner_idx;
    end
  end

  always_comb begin
    pick_idx = 1'b0;
    pick     = '0;
    if (req[0] && req[1]) begin
      pick_idx = ~last_idx_q;
    end else if (req[1]) begin
      pick_idx = 1'b1;
    end
    if (|req) begin
      pick[pick_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES controller between two requesters.
// A job is latched in ARB, issued with aes_start held until aes_done, and
// released once aes_done falls again.
//
// Handshake: req[i] is a level held until done_pulse[i]; aes_start is a
// level held with a stable command until aes_done is sampled high, after
// which aes_start drops and the arbiter waits for aes_done to fall before
// releasing grant.
//
// Optional feature: define AES_ARB_TIMEOUT_EN to abort an ISSUE that waits
// TIMEOUT_CYC cycles without aes_done (err[owner] pulses instead of
// done_pulse). Without it err is tied to zero and ISSUE waits forever.
//
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   req[1:0]          : per-requester job request level
//   req_key/addr/loc/mode : per-requester job fields, requester i at slot i
//   grant[1:0]        : one-hot engine owner, zero when idle
//   done_pulse[1:0]   : one-cycle completion strobe to the owner
//   err[1:0]          : one-cycle timeout strobe to the owner
//   aes_start, aes_key, aes_addr, aes_loc, aes_mode : command to AES (zero when aes_start=0)
//   aes_done          : AES controller done level
//   busy              : high whenever the FSM is not IDLE
//   dbg_state         : current FSM state for observation
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
)
(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*KEY_W-1:0] req_key,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LOC_W-1:0] req_loc,
  input  logic [N_REQ-1:0]       req_mode,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done_pulse,
  output logic [N_REQ-1:0]       err,
  output logic                   aes_start,
  output logic [KEY_W-1:0]       aes_key,
  output logic [ADDR_W-1:0]      aes_addr,
  output logic [LOC_W-1:0]       aes_loc,
  output logic                   aes_mode,
  input  logic                   aes_done,
  output logic                   busy,
  output aes_arb_state_e         dbg_state
);

  aes_arb_state_e   state_q, state_d;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic [IDX_W-1:0] owner_q;
  logic [KEY_W-1:0] key_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LOC_W-1:0] loc_q;
  logic             mode_q;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             timeout_hit;
  logic             release_done;

  assign release_done = (state_q == ST_RELEASE) && !aes_done;

  aes_rr_arbiter u_rr (
    .clk       (clk),
    .n_rst     (n_rst),
    .req       (req),
    .advance   (release_done),
    .owner_idx (owner_q),
    .pick      (pick),
    .pick_idx  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req) state_d = ST_ARB;
      // A request withdrawn before arbitration leaves nothing to latch.
      ST_ARB:     state_d = (|req) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   if (aes_done || timeout_hit) state_d = ST_RELEASE;
      ST_RELEASE: if (!aes_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      loc_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      if ((state_q == ST_ARB) && (|req)) begin
        grant_q <= pick;
        owner_q <= pick_idx;
        key_q   <= req_key[int'(pick_idx)*KEY_W +: KEY_W];
        addr_q  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        loc_q   <= req_loc[int'(pick_idx)*LOC_W +: LOC_W];
        mode_q  <= req_mode[pick_idx];
      end
      // aes_done wins over a coincident timeout.
      if ((state_q == ST_ISSUE) && aes_done) begin
        done_q <= grant_q;
      end
      if (release_done) begin
        grant_q <= '0;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] err_q;

  assign timeout_hit = (state_q == ST_ISSUE) && !aes_done &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Cleared in ARB so the first ISSUE cycle sees zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (state_q == ST_ARB) begin
        cnt_q <= '0;
      end else if (state_q == ST_ISSUE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= grant_q;
      end
    end
  end

  assign err = err_q;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYC == 0);
  assign timeout_hit        = 1'b0;
  assign err                = '0;
`endif

  assign aes_start  = (state_q == ST_ISSUE);
  assign aes_key    = aes_start ? key_q  : '0;
  assign aes_addr   = aes_start ? addr_q : '0;
  assign aes_loc    = aes_start ? loc_q  : '0;
  assign aes_mode   = aes_start ? mode_q : 1'b0;
  assign grant      = grant_q;
  assign done_pulse = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Testbench for aes_job_arbiter: scenario tasks plus randomized jobs checked
// against a transaction-level round-robin model and an expected-command queue.
module tb_aes_job_arbiter;
  import aes_arb_pkg::*;

  localparam int TO    = 16;
  localparam int CMD_W = 1 + LOC_W + ADDR_W + KEY_W;

  logic                    clk = 1'b0;
  logic                    n_rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*KEY_W-1:0]  req_key;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LOC_W-1:0]  req_loc;
  logic [N_REQ-1:0]        req_mode;
  logic [N_REQ-1:0]        grant, done_pulse, err;
  logic                    aes_start, aes_mode, aes_done, busy;
  logic [KEY_W-1:0]        aes_key;
  logic [ADDR_W-1:0]       aes_addr;
  logic [LOC_W-1:0]        aes_loc;
  aes_arb_state_e          dbg_state;

  int checks = 0;
  int errors = 0;
  int model_last = 1;
  logic [CMD_W-1:0] exp_q[$];

  aes_job_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_key(req_key), .req_addr(req_addr),
    .req_loc(req_loc), .req_mode(req_mode), .grant(grant), .done_pulse(done_pulse),
    .err(err), .aes_start(aes_start), .aes_key(aes_key), .aes_addr(aes_addr),
    .aes_loc(aes_loc), .aes_mode(aes_mode), .aes_done(aes_done), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- model / driver helpers ----------------
  // Round-robin rule: on a tie the requester not granted last wins.
  function automatic int model_pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    if (r[1]) return 1;
    return 0;
  endfunction

  function automatic logic [CMD_W-1:0] cmd_of(input int i);
    return {req_mode[i], req_loc[LOC_W*i +: LOC_W], req_addr[ADDR_W*i +: ADDR_W],
            req_key[KEY_W*i +: KEY_W]};
  endfunction

  function automatic logic [CMD_W-1:0] dut_cmd();
    return {aes_mode, aes_loc, aes_addr, aes_key};
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_requester(input int i, input logic [KEY_W-1:0] k,
                               input logic [7:0] a, input logic [7:0] l, input logic m);
    req_key[KEY_W*i +: KEY_W]    = k;
    req_addr[ADDR_W*i +: ADDR_W] = a;
    req_loc[LOC_W*i +: LOC_W]    = l;
    req_mode[i]                  = m;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; req = '0; aes_done = 1'b0;
    repeat (2) step();
    n_rst = 1'b1;
    step();
    model_last = 1;
    exp_q.delete();
  endtask

  task automatic wait_start(input int bound, output int cycles, output bit ok);
    cycles = 0;
    while (cycles < bound && aes_start !== 1'b1) begin
      step();
      cycles++;
    end
    ok = (aes_start === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0; req = '0; req_key = '0; req_addr = '0; req_loc = '0;
    req_mode = '0; aes_done = 1'b0;
    repeat (2) step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %0h expected 0", grant); end
    checks++; if (done_pulse !== 2'b00) begin errors++; $display("FAIL reset_done: got %0h expected 0", done_pulse); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %0h expected 0", err); end
    checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", aes_start); end
    checks++; if (dut_cmd() !== '0) begin errors++; $display("FAIL reset_cmd: got %0h expected 0", dut_cmd()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_rst = 1'b1;
    step();
    model_last = 1;
  endtask

  task automatic test_single_job();
    logic [KEY_W-1:0] k;
    int cyc; bit ok; bit stable;
    k = rand_key();
    set_requester(0, k, 8'h10, 8'h04, 1'b0);
    req = 2'b01;
    wait_start(8, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_start: got no aes_start expected within 8 cycles"); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %0h expected 1", grant); end
    checks++; if (aes_addr !== 8'h10 || aes_loc !== 8'h04 || aes_mode !== 1'b0 || aes_key !== k)
      begin errors++; $display("FAIL single_cmd: got %0h expected %0h", dut_cmd(), {1'b0, 8'h04, 8'h10, k}); end
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (aes_start !== 1'b1 || aes_addr !== 8'h10 || aes_key !== k) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL single_hold: got unstable command expected stable for 20 cycles"); end
    aes_done = 1'b1;
    step();
    checks++; if (done_pulse !== 2'b01) begin errors++; $display("FAIL single_done: got %0h expected 1", done_pulse); end
    checks++; if (aes_start !== 1'b0 || dut_cmd() !== '0) begin errors++; $display("FAIL single_start_low: got start=%0b cmd=%0h expected 0", aes_start, dut_cmd()); end
    req = 2'b00;
    step();
    checks++; if (grant !== 2'b01 || done_pulse !== 2'b00) begin errors++; $display("FAIL single_release: got grant=%0h done=%0h expected 1/0", grant, done_pulse); end
    aes_done = 1'b0;
    step();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got grant=%0h busy=%0b expected 0/0", grant, busy); end
    model_last = 0;
  endtask

  task automatic test_contention();
    int cyc; bit ok; int w;
    logic [CMD_W-1:0] exp;
    do_reset();
    set_requester(0, rand_key(), 8'(($urandom)), 8'(($urandom)), 1'b0);
    set_requester(1, rand_key(), 8'(($urandom)), 8'(($urandom)), 1'b1);
    req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      w = model_pick(2'b11, model_last);
      exp = cmd_of(w);
      wait_start(8, cyc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cont_start%0d: got no aes_start expected one", j); end
      if (j > 0) begin
        checks++; if (cyc != 3) begin errors++; $display("FAIL cont_gap%0d: got %0d expected 3", j, cyc); end
      end
      checks++; if (grant !== 2'(1 << w)) begin errors++; $display("FAIL cont_grant%0d: got %0h expected %0h", j, grant, 2'(1 << w)); end
      checks++; if (dut_cmd() !== exp) begin errors++; $display("FAIL cont_cmd%0d: got %0h expected %0h", j, dut_cmd(), exp); end
      repeat (3) step();
      aes_done = 1'b1;
      step();
      checks++; if (done_pulse !== 2'(1 << w)) begin errors++; $display("FAIL cont_done%0d: got %0h expected %0h", j, done_pulse, 2'(1 << w)); end
      aes_done = 1'b0;
      model_last = w;
    end
    req = 2'b00;
    step();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL cont_idle: got grant=%0h busy=%0b expected 0/0", grant, busy); end
  endtask

  task automatic test_mid_job();
    logic [KEY_W-1:0] k;
    logic [CMD_W-1:0] exp;
    int cyc; bit ok;
    k = rand_key();
    set_requester(1, k, 8'h5a, 8'h21, 1'b1);
    exp = cmd_of(1);
    req = 2'b10;
    wait_start(8, cyc, ok);
    checks++; if (!ok || grant !== 2'b10) begin errors++; $display("FAIL mid_grant: got %0h expected 2", grant); end
    req_key = ~req_key; req_addr = ~req_addr; req_mode = ~req_mode; req = 2'b00;
    repeat (5) step();
    checks++; if (aes_key !== k || dut_cmd() !== exp) begin errors++; $display("FAIL mid_latched: got %0h expected %0h", dut_cmd(), exp); end
    aes_done = 1'b1;
    step();
    checks++; if (done_pulse !== 2'b10) begin errors++; $display("FAIL mid_done: got %0h expected 2", done_pulse); end
    aes_done = 1'b0;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_idle: got %0h expected 0", grant); end
    model_last = 1;
  endtask

  task automatic test_pending();
    logic [CMD_W-1:0] exp0;
    int cyc; bit ok;
    set_requester(0, rand_key(), 8'h33, 8'h01, 1'b0);
    set_requester(1, rand_key(), 8'h44, 8'h02, 1'b1);
    exp0 = cmd_of(0);
    req = 2'b01;
    wait_start(8, cyc, ok);
    checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL pend_grant0: got %0h expected 1", grant); end
    step();
    req = 2'b11;
    repeat (4) step();
    checks++; if (grant !== 2'b01 || dut_cmd() !== exp0) begin errors++; $display("FAIL pend_no_preempt: got grant=%0h cmd=%0h expected 1/%0h", grant, dut_cmd(), exp0); end
    aes_done = 1'b1;
    step();
    checks++; if (done_pulse !== 2'b01) begin errors++; $display("FAIL pend_done0: got %0h expected 1", done_pulse); end
    aes_done = 1'b0;
    req = 2'b10;
    wait_start(8, cyc, ok);
    checks++; if (!ok || cyc != 3 || grant !== 2'b10) begin errors++; $display("FAIL pend_next: got gap=%0d grant=%0h expected 3/2", cyc, grant); end
    aes_done = 1'b1;
    step();
    checks++; if (done_pulse !== 2'b10) begin errors++; $display("FAIL pend_done1: got %0h expected 2", done_pulse); end
    aes_done = 1'b0; req = 2'b00;
    step();
    model_last = 1;
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    set_requester(0, rand_key(), 8'h77, 8'h08, 1'b1);
    req = 2'b01;
    wait_start(8, cyc, ok);
    checks++; if (!ok || grant !== 2'b01) begin errors++; $display("FAIL to_grant: got %0h expected 1", grant); end
`ifdef AES_ARB_TIMEOUT_EN
    cyc = 0;
    while (cyc < TO + 10 && err === 2'b00) begin
      step();
      cyc++;
      if (done_pulse !== 2'b00) begin errors++; $display("FAIL to_no_done: got %0h expected 0", done_pulse); end
    end
    checks++; if (cyc != TO) begin errors++; $display("FAIL to_latency: got %0d expected %0d", cyc, TO); end
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL to_err: got %0h expected 1", err); end
    checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL to_start_low: got %0b expected 0", aes_start); end
    req = 2'b00;
    step();
    checks++; if (err !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL to_idle: got err=%0h grant=%0h busy=%0b expected 0", err, grant, busy); end
`else
    ok = 1'b1;
    for (int c = 0; c < TO + 10; c++) begin
      step();
      if (err !== 2'b00 || aes_start !== 1'b1) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL to_wait_forever: got abort expected indefinite ISSUE"); end
    aes_done = 1'b1;
    step();
    checks++; if (done_pulse !== 2'b01 || err !== 2'b00) begin errors++; $display("FAIL to_done: got done=%0h err=%0h expected 1/0", done_pulse, err); end
    aes_done = 1'b0; req = 2'b00;
    step();
`endif
    model_last = 0;
  endtask

  task automatic test_reset_in_issue();
    int cyc; bit ok;
    set_requester(0, rand_key(), 8'h12, 8'h34, 1'b0);
    req = 2'b01;
    wait_start(8, cyc, ok);
    repeat (3) step();
    n_rst = 1'b0;
    #1;
    checks++; if (aes_start !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || dut_cmd() !== '0)
      begin errors++; $display("FAIL rst_async: got start=%0b grant=%0h busy=%0b expected 0", aes_start, grant, busy); end
    step(); step();
    checks++; if (done_pulse !== 2'b00 || err !== 2'b00) begin errors++; $display("FAIL rst_no_strobe: got done=%0h err=%0h expected 0", done_pulse, err); end
    n_rst = 1'b1;
    model_last = 1;
    set_requester(1, rand_key(), 8'h9c, 8'h03, 1'b1);
    req = 2'b10;
    wait_start(8, cyc, ok);
    checks++; if (!ok || grant !== 2'b10) begin errors++; $display("FAIL rst_regrant: got %0h expected 2", grant); end
    aes_done = 1'b1;
    step();
    aes_done = 1'b0; req = 2'b00;
    step();
    model_last = 1;
  endtask

  task automatic test_random_jobs();
    logic [1:0] r;
    logic [CMD_W-1:0] exp;
    int w, cyc, delay, hold; bit ok, stable, held;
    for (int it = 0; it < 16; it++) begin
      r = 2'($urandom_range(1, 3));
      for (int i = 0; i < N_REQ; i++)
        set_requester(i, rand_key(), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      w = model_pick(r, model_last);
      exp_q.push_back(cmd_of(w));
      req = r;
      wait_start(8, cyc, ok);
      exp = exp_q.pop_front();
      checks++; if (!ok || grant !== 2'(1 << w)) begin errors++; $display("FAIL rnd_grant%0d: got %0h expected %0h", it, grant, 2'(1 << w)); end
      checks++; if (dut_cmd() !== exp) begin errors++; $display("FAIL rnd_cmd%0d: got %0h expected %0h", it, dut_cmd(), exp); end
      req_key = {rand_key(), rand_key()}; req_addr = 16'($urandom); req = 2'($urandom_range(0, 3));
      delay = $urandom_range(1, 8);
      stable = 1'b1;
      for (int c = 0; c < delay; c++) begin
        step();
        if (aes_start !== 1'b1 || dut_cmd() !== exp || grant !== 2'(1 << w)) stable = 1'b0;
      end
      checks++; if (!stable) begin errors++; $display("FAIL rnd_stable%0d: got changed command expected %0h", it, exp); end
      aes_done = 1'b1;
      step();
      checks++; if (done_pulse !== 2'(1 << w) || aes_start !== 1'b0 || dut_cmd() !== '0)
        begin errors++; $display("FAIL rnd_done%0d: got done=%0h start=%0b expected %0h/0", it, done_pulse, aes_start, 2'(1 << w)); end
      req = 2'b00;
      hold = $urandom_range(0, 2);
      held = 1'b1;
      for (int c = 0; c < hold; c++) begin
        step();
        if (grant !== 2'(1 << w) || done_pulse !== 2'b00) held = 1'b0;
      end
      checks++; if (!held) begin errors++; $display("FAIL rnd_release%0d: got grant=%0h expected held %0h", it, grant, 2'(1 << w)); end
      aes_done = 1'b0;
      step();
      checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: got grant=%0h busy=%0b expected 0/0", it, grant, busy); end
      model_last = w;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_mid_job();
    test_pending();
    test_timeout();
    test_reset_in_issue();
    test_random_jobs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
